// File: rtl/mem_map_rst_ctrl.sv
// Memory-mapped reset controller: per-channel level HOLD plus timed PULSE resets, output is their OR.
// Latency: a register write changes rst_n_out on its accepting edge; no wait states, never backpressures.
module mem_map_rst_ctrl #(
    parameter int                CH_NUM   = 4,
    parameter int                CNT_W    = 16,
    parameter logic [CH_NUM-1:0] HOLD_RST = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              write,
    input  logic              chipselect,
    output logic [CH_NUM-1:0] rst_n_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t             state     [CH_NUM];
    state_t             state_nxt [CH_NUM];
    logic [CNT_W-1:0]   cnt       [CH_NUM];
    logic [CNT_W-1:0]   cnt_nxt   [CH_NUM];
    logic [CH_NUM-1:0]  hold;
    logic [CH_NUM-1:0]  hold_nxt;
    logic [CH_NUM-1:0]  busy;
    logic [CH_NUM-1:0]  busy_nxt;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   len_nxt;
    logic [CNT_W-1:0]   len_eff;
    logic               wr_en;
    logic               unused_wdata;

    assign wr_en        = chipselect && write;
    assign unused_wdata = &{1'b0, writedata};

    always_comb begin
        hold_nxt = hold;
        len_nxt  = len;
        if (wr_en && address == 2'd0) hold_nxt = writedata[CH_NUM-1:0];
        if (wr_en && address == 2'd2) len_nxt  = writedata[CNT_W-1:0];
    end

    // A programmed length of zero behaves as a single-cycle pulse.
    assign len_eff = (len == '0) ? CNT_W'(1) : len;

    // Trigger wins over expiry; trigger and abort live at different addresses so never collide.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            if (wr_en && address == 2'd1 && writedata[i]) begin
                state_nxt[i] = PULSE;
                cnt_nxt[i]   = len_eff;
            end else if (wr_en && address == 2'd3 && writedata[i]) begin
                state_nxt[i] = IDLE;
                cnt_nxt[i]   = '0;
            end else if (state[i] == PULSE) begin
                if (cnt[i] == CNT_W'(1)) state_nxt[i] = IDLE;
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
            busy_nxt[i] = (state_nxt[i] == PULSE);
            busy[i]     = (state[i] == PULSE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= HOLD_RST;
            len       <= CNT_W'(1);
            rst_n_out <= ~HOLD_RST;
            for (int i = 0; i < CH_NUM; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            hold      <= hold_nxt;
            len       <= len_nxt;
            rst_n_out <= ~(hold_nxt | busy_nxt);
            for (int i = 0; i < CH_NUM; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[CH_NUM-1:0] = hold;
            2'd1:    readdata[CH_NUM-1:0] = busy;
            2'd2:    readdata[CNT_W-1:0]  = len;
            default: readdata[CH_NUM-1:0] = ~rst_n_out;
        endcase
    end

endmodule

// File: tb/tb_mem_map_rst_ctrl.sv
// Directed bench for mem_map_rst_ctrl; expectations are queued by the stimulus and compared by a monitor.
module tb_mem_map_rst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        write;
    logic        chipselect;
    logic [3:0]  rst_n_out;

    mem_map_rst_ctrl #(
        .CH_NUM  (4),
        .CNT_W   (16),
        .HOLD_RST(4'hF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .write     (write),
        .chipselect(chipselect),
        .rst_n_out (rst_n_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_rd;
        logic [31:0] rd;
        logic [3:0]  rn;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e.chk_rd) begin
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL %s readdata got %h expected %h", n, readdata, e.rd);
                end
            end
            checks++;
            if (rst_n_out !== e.rn) begin
                errors++;
                $display("FAIL %s rst_n_out got %b expected %b", n, rst_n_out, e.rn);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic chk_rd, input logic [31:0] rd, input logic [3:0] rn,
                        input string name);
        exp_t e;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        e.rn     = rn;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    // Write whose own cycle is also checked for rst_n_out.
    task automatic wr_chk(input logic [1:0] a, input logic [31:0] d, input logic [3:0] rn,
                          input string name);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        push(1'b0, 32'h0, rn, name);
        cyc();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic check(input logic [1:0] a, input logic [31:0] rd, input logic [3:0] rn,
                         input string name);
        address = a;
        push(1'b1, rd, rn, name);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        write      = 1'b0;
        chipselect = 1'b0;
        cyc();
        cyc();
        check(2'd0, 32'hF, 4'b0000, "rst_hold");
        check(2'd2, 32'h1, 4'b0000, "rst_len");
        check(2'd1, 32'h0, 4'b0000, "rst_busy");
        rst = 1'b0;
        check(2'd0, 32'hF, 4'b0000, "rel_hold");
        check(2'd3, 32'hF, 4'b0000, "rel_status");

        // HOLD clear, upper bits ignored
        do_write(2'd0, 32'hFFFF_FFF0);
        check(2'd0, 32'h0, 4'b1111, "hold_clr");
        check(2'd3, 32'h0, 4'b1111, "status_clr");

        // LEN keeps only its low 16 bits
        do_write(2'd2, 32'hABCD_0005);
        check(2'd2, 32'h5, 4'b1111, "len5");

        do_write(2'd1, 32'h2);
        repeat (5) check(2'd1, 32'h2, 4'b1101, "pulse5_low");
        check(2'd1, 32'h0, 4'b1111, "pulse5_end");

        do_write(2'd2, 32'h0);
        check(2'd2, 32'h0, 4'b1111, "len0_read");
        do_write(2'd1, 32'h1);
        check(2'd1, 32'h1, 4'b1110, "len0_low");
        check(2'd1, 32'h0, 4'b1111, "len0_end");

        // LEN change mid-pulse leaves the running count alone
        do_write(2'd2, 32'h3);
        do_write(2'd1, 32'h1);
        check(2'd2, 32'h3, 4'b1110, "lenrun_w0");
        wr_chk(2'd2, 32'h8, 4'b1110, "lenrun_w1");
        check(2'd2, 32'h8, 4'b1110, "lenrun_w2");
        check(2'd1, 32'h0, 4'b1111, "lenrun_end");

        // Retrigger in the cycle the count reaches one
        do_write(2'd2, 32'd10);
        do_write(2'd1, 32'h4);
        repeat (9) check(2'd1, 32'h4, 4'b1011, "rt_first");
        wr_chk(2'd1, 32'h4, 4'b1011, "rt_at_one");
        repeat (10) check(2'd3, 32'h4, 4'b1011, "rt_ext");
        check(2'd1, 32'h0, 4'b1111, "rt_end");

        do_write(2'd1, 32'h4);
        check(2'd3, 32'h4, 4'b1011, "ab_pre");
        do_write(2'd3, 32'h4);
        check(2'd1, 32'h0, 4'b1111, "ab_busy");
        check(2'd0, 32'h0, 4'b1111, "ab_hold");

        // Clearing HOLD mid-pulse does not shorten the pulse
        do_write(2'd2, 32'd4);
        do_write(2'd0, 32'h8);
        check(2'd0, 32'h8, 4'b0111, "hold3");
        do_write(2'd1, 32'h8);
        check(2'd1, 32'h8, 4'b0111, "hp_w0");
        wr_chk(2'd0, 32'h0, 4'b0111, "hp_w1");
        check(2'd1, 32'h8, 4'b0111, "hp_w2");
        check(2'd1, 32'h8, 4'b0111, "hp_w3");
        check(2'd1, 32'h0, 4'b1111, "hp_end");

        // Pulse expiry while HOLD is set keeps the channel in reset
        do_write(2'd0, 32'h8);
        do_write(2'd1, 32'h8);
        repeat (4) check(2'd1, 32'h8, 4'b0111, "ph_low");
        check(2'd1, 32'h0, 4'b0111, "ph_held");
        do_write(2'd0, 32'h0);
        check(2'd3, 32'h0, 4'b1111, "ph_rel");

        // Reset mid-pulse
        do_write(2'd1, 32'h2);
        check(2'd1, 32'h2, 4'b1101, "rm_pre");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check(2'd1, 32'h0, 4'b0000, "rm_busy");
        check(2'd0, 32'hF, 4'b0000, "rm_hold");
        check(2'd2, 32'h1, 4'b0000, "rm_len");
        do_write(2'd0, 32'h0);
        repeat (4) check(2'd1, 32'h0, 4'b1111, "rm_noretain");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
